// File: rtl/xoodoo_pkg.sv
// Shared definitions for the Xoodoo permutation arbiter and its round datapath.
//   STATE_W / LANE_W : permutation state width and lane width
//   XOODOO_RC        : 12-entry round-constant table, index 0..11
//   fsm_state_e      : sequencer states (IDLE, RUN, DONE)
//   rotl32           : 32-bit left rotation helper
//   rc_at            : bounds-safe round-constant lookup
package xoodoo_pkg;

  localparam int STATE_W = 384;
  localparam int LANE_W  = 32;

  localparam logic [9:0] XOODOO_RC [0:11] = '{
    10'h058, 10'h038, 10'h3C0, 10'h0D0, 10'h120, 10'h014,
    10'h060, 10'h02C, 10'h380, 10'h0F0, 10'h1A0, 10'h012
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Only ever called with constant amounts in 1..31.
  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // The counter never exceeds 11; the default arm only keeps the lookup total.
  function automatic logic [9:0] rc_at(input logic [3:0] idx);
    case (idx)
      4'd0:    return XOODOO_RC[0];
      4'd1:    return XOODOO_RC[1];
      4'd2:    return XOODOO_RC[2];
      4'd3:    return XOODOO_RC[3];
      4'd4:    return XOODOO_RC[4];
      4'd5:    return XOODOO_RC[5];
      4'd6:    return XOODOO_RC[6];
      4'd7:    return XOODOO_RC[7];
      4'd8:    return XOODOO_RC[8];
      4'd9:    return XOODOO_RC[9];
      4'd10:   return XOODOO_RC[10];
      4'd11:   return XOODOO_RC[11];
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One Xoodoo round, purely combinational.
//   state      : 384-bit input state, bit 32*(4*y+x)+z is lane (x,y) bit z
//   rc         : 10-bit round constant, XORed into lane (0,0) bits [9:0]
//   next_state : state after theta, rho-west, iota, chi, rho-east
module xoodoo_round
  import xoodoo_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [9:0]         rc,
  output logic [STATE_W-1:0] next_state
);

  // Lane arrays are indexed [y][x] (plane, column).
  logic [LANE_W-1:0] a  [3][4];
  logic [LANE_W-1:0] p  [4];
  logic [LANE_W-1:0] e  [4];
  logic [LANE_W-1:0] th [3][4];
  logic [LANE_W-1:0] rw [3][4];
  logic [LANE_W-1:0] io [3][4];
  logic [LANE_W-1:0] ch [3][4];
  logic [LANE_W-1:0] re [3][4];

  for (genvar y = 0; y < 3; y++) begin : g_plane
    for (genvar x = 0; x < 4; x++) begin : g_lane
      assign a[y][x] = state[LANE_W*(4*y+x) +: LANE_W];
      // theta: every plane absorbs the column-parity effect
      assign th[y][x] = a[y][x] ^ e[x];
      // iota touches lane (0,0) only
      if (y == 0 && x == 0) begin : g_iota
        assign io[y][x] = rw[y][x] ^ {22'd0, rc};
      end else begin : g_pass
        assign io[y][x] = rw[y][x];
      end
      // chi: plane y ^= ~plane(y+1) & plane(y+2)
      assign ch[y][x] = io[y][x] ^ (~io[(y+1)%3][x] & io[(y+2)%3][x]);
      assign next_state[LANE_W*(4*y+x) +: LANE_W] = re[y][x];
    end
  end

  for (genvar x = 0; x < 4; x++) begin : g_col
    assign p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    // column parity shifted by (1,5) and (1,14)
    assign e[x] = rotl32(p[(x+3)%4], 5) ^ rotl32(p[(x+3)%4], 14);
    // rho-west: plane 1 shifted by (1,0), plane 2 by (0,11)
    assign rw[0][x] = th[0][x];
    assign rw[1][x] = th[1][(x+3)%4];
    assign rw[2][x] = rotl32(th[2][x], 11);
    // rho-east: plane 1 shifted by (0,1), plane 2 by (2,8)
    assign re[0][x] = ch[0][x];
    assign re[1][x] = rotl32(ch[1][x], 1);
    assign re[2][x] = rotl32(ch[2][(x+2)%4], 8);
  end

endmodule

// File: rtl/xoodoo_perm_arbiter.sv
// Round-robin arbiter and sequencer sharing one Xoodoo round datapath between
// two requesters.
//   clk, resetn           : clock, asynchronous active-low reset
//   req0/req1             : level requests; state_inN stable until grantN
//   state_in0/state_in1   : 384-bit states captured at acceptance
//   grant0/grant1         : one-cycle pulse the cycle after acceptance
//   done0/done1           : one-cycle pulse, result valid on state_out
//   state_out             : working state register (final value in done cycle)
//   busy                  : high from acceptance through the done cycle
//   dbg_state             : current sequencer state
//
// Handshake: a request is taken on an IDLE clock edge; the requester sees
// grantN for exactly one cycle and must drop reqN in that cycle, otherwise the
// still-high level counts as a fresh request at the next IDLE edge.
module xoodoo_perm_arbiter
  import xoodoo_pkg::*;
#(
  parameter int NROUNDS = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req0,
  input  logic [STATE_W-1:0] state_in0,
  input  logic               req1,
  input  logic [STATE_W-1:0] state_in1,
  output logic               grant0,
  output logic               grant1,
  output logic               done0,
  output logic               done1,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output fsm_state_e         dbg_state
);

  // Runs use the last NROUNDS constants of the table.
  localparam logic [3:0] RND_FIRST = 4'(12 - NROUNDS);

  fsm_state_e         state_q, state_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [1:0]         grant_q, grant_d;
  logic               winner;
  logic [STATE_W-1:0] round_out;

  xoodoo_round u_round (
    .state      (st_q),
    .rc         (rc_at(rnd_q)),
    .next_state (round_out)
  );

  // On a tie the requester that did not own the previous run wins.
  always_comb begin
    if (req0 && req1) winner = ~last_q;
    else              winner = req1;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          st_d    = winner ? state_in1 : state_in0;
          owner_d = winner;
          last_d  = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          rnd_d   = RND_FIRST;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d = round_out;
        // Counter saturates at 11 so it can never index past the table.
        if (rnd_q == 4'd11) state_d = DONE;
        else                rnd_d   = rnd_q + 4'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    grant0    = grant_q[0];
    grant1    = grant_q[1];
    done0     = (state_q == DONE) && !owner_q;
    done1     = (state_q == DONE) &&  owner_q;
    busy      = (state_q != IDLE);
    state_out = st_q;
    dbg_state = state_q;
  end

endmodule
